// File: rtl/dac_pkg.sv
// dac_pkg: DEM mode codes, LFSR reset seed, LFSR taps and step function
package dac_pkg;
  localparam logic [1:0] DEM_STATIC = 2'd0;
  localparam logic [1:0] DEM_SEQ    = 2'd1;
  localparam logic [1:0] DEM_DWA    = 2'd2;
  localparam logic [1:0] DEM_RAND   = 2'd3;
  localparam logic [15:0] LFSR_RESET_SEED = 16'hACE1;
  localparam int LFSR_TAP_A = 15;
  localparam int LFSR_TAP_B = 13;
  localparam int LFSR_TAP_C = 12;
  localparam int LFSR_TAP_D = 10;
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction
endpackage

// File: rtl/dac_dem_pointer.sv
// dac_dem_pointer: DEM pointer/LFSR state and next rotation index from pre-update state
module dac_dem_pointer
  import dac_pkg::*;
#(
  parameter int CODE_WIDTH  = 8,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   accept,
  input  logic [1:0]             dem_mode,
  input  logic [CODE_WIDTH-1:0]  sample_code,
  input  logic                   lfsr_load,
  input  logic [15:0]            lfsr_seed,
  output logic [INDEX_WIDTH-1:0] next_index
);
  localparam logic [CODE_WIDTH-1:0] SEQ_STEP = CODE_WIDTH'(1) << (CODE_WIDTH - INDEX_WIDTH);
  logic [CODE_WIDTH-1:0] ptr_acc_q, ptr_acc_d;
  logic [15:0]           lfsr_q, lfsr_d;
  always_comb begin
    ptr_acc_d  = !accept               ? ptr_acc_q :
                 dem_mode == DEM_SEQ   ? ptr_acc_q + SEQ_STEP :
                 dem_mode == DEM_DWA   ? ptr_acc_q + sample_code : ptr_acc_q;
    // a zero seed would lock the LFSR, so it is promoted to 1
    lfsr_d     = lfsr_load                        ? (lfsr_seed == 16'd0 ? 16'h0001 : lfsr_seed) :
                 (accept && dem_mode == DEM_RAND) ? lfsr_step(lfsr_q) : lfsr_q;
    next_index = dem_mode == DEM_STATIC ? '0 :
                 dem_mode == DEM_RAND   ? lfsr_q[INDEX_WIDTH-1:0] :
                                          ptr_acc_q[CODE_WIDTH-1 -: INDEX_WIDTH];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_acc_q <= '0;
      lfsr_q    <= LFSR_RESET_SEED;
    end else begin
      ptr_acc_q <= ptr_acc_d;
      lfsr_q    <= lfsr_d;
    end
  end
endmodule

// File: rtl/dac_thermometer_encoder_dem.sv
// dac_thermometer_encoder_dem: registered binary-to-thermometer encoder with DEM rotation index
module dac_thermometer_encoder_dem
  import dac_pkg::*;
#(
  parameter int THERMOMETER_WIDTH = 256,
  parameter int CODE_WIDTH        = 8,
  parameter int INDEX_WIDTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         sample_valid,
  input  logic [CODE_WIDTH-1:0]        sample_code,
  input  logic [1:0]                   dem_mode,
  input  logic                         lfsr_load,
  input  logic [15:0]                  lfsr_seed,
  output logic [THERMOMETER_WIDTH-1:0] output_thermometer,
  output logic [INDEX_WIDTH-1:0]       cycle_index,
  output logic                         output_valid
);
  logic                         accept;
  logic [THERMOMETER_WIDTH-1:0] therm_enc, therm_q, therm_d;
  logic [INDEX_WIDTH-1:0]       next_index, index_q, index_d;
  logic                         valid_q, valid_d;
  assign accept = enable & sample_valid;
  // one flat compare per bit keeps the encoder a single logic level
  for (genvar i = 0; i < THERMOMETER_WIDTH; i++) begin : g_enc
    assign therm_enc[i] = 32'(i) < 32'(sample_code);
  end
  dac_dem_pointer #(
    .CODE_WIDTH (CODE_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_pointer (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept),
    .dem_mode   (dem_mode),
    .sample_code(sample_code),
    .lfsr_load  (lfsr_load),
    .lfsr_seed  (lfsr_seed),
    .next_index (next_index)
  );
  always_comb begin
    therm_d = accept ? therm_enc : therm_q;
    index_d = accept ? next_index : index_q;
    valid_d = accept;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      therm_q <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
    end else begin
      therm_q <= therm_d;
      index_q <= index_d;
      valid_q <= valid_d;
    end
  end
  assign output_thermometer = therm_q;
  assign cycle_index        = index_q;
  assign output_valid       = valid_q;
endmodule

// File: doc/dac_thermometer_encoder_dem.md
# dac_thermometer_encoder_dem

Registered front end of the segmented current-steering DAC. Accepts one binary sample code per valid cycle and produces the registered unary (thermometer) word. It also produces the matching `cycle_index` that selects the rotation for the downstream thermometer cycling stage. The index is generated by a selectable dynamic-element-matching (DEM) policy: static, sequential rotation, data-weighted averaging, or pseudo-random.

## Interface
- `THERMOMETER_WIDTH`, 256: unary output width; must equal 2**CODE_WIDTH.
- `CODE_WIDTH`, 8: binary sample code width.
- `INDEX_WIDTH`, 4: rotation index width; must be ≤ CODE_WIDTH and ≤ 16.

Ports (direction, width, meaning):
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: block enable; when low, no sample is accepted.
- `sample_valid` in 1: `sample_code` is valid this cycle.
- `sample_code` in CODE_WIDTH: unsigned amplitude code.
- `dem_mode` in 2: 0 static, 1 sequential, 2 data-weighted, 3 random.
- `lfsr_load` in 1: single-cycle pulse; loads `lfsr_seed`.
- `lfsr_seed` in 16: LFSR seed value.
- `output_thermometer` out THERMOMETER_WIDTH: registered unary word.
- `cycle_index` out INDEX_WIDTH: registered rotation index, aligned to `output_thermometer`.
- `output_valid` out 1: outputs were updated this cycle.

## Operation
- **Accept:** a sample is accepted when `accept = enable & sample_valid`.
- **Thermometer encoding:** for code N, bits [N-1:0] of `output_thermometer` are 1 and all other bits are 0.
  - N=0 gives all zeros.
  - Bit THERMOMETER_WIDTH-1 is never set.
- **Index registers and outputs:** internal state is `ptr_acc` (CODE_WIDTH bits) and `lfsr` (16 bits). On accept, `cycle_index` is loaded as follows, using pre-update state:
  - Mode 0: 0.
  - Mode 1: `ptr_acc[CODE_WIDTH-1 -: INDEX_WIDTH]`, then `ptr_acc += 2**(CODE_WIDTH-INDEX_WIDTH)`, modulo 2**CODE_WIDTH.
  - Mode 2: `ptr_acc[CODE_WIDTH-1 -: INDEX_WIDTH]`, then `ptr_acc += sample_code`, modulo 2**CODE_WIDTH. The residue below the index bits is kept, so wrap-around is exact.
  - Mode 3: `lfsr[INDEX_WIDTH-1:0]`, then the LFSR steps once.
- **LFSR:** Fibonacci, x^16+x^14+x^13+x^11+1.
  - Step: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
  - The LFSR steps only on accepted samples in mode 3.
- **LFSR seed load:** `lfsr_load` takes priority over stepping in the same cycle.
  - The sample accepted in that cycle uses the old `lfsr` value.
  - The state then becomes the seed.
  - A seed of 0 is replaced by 16'h0001, so the LFSR never locks up.
- **Mode changes:**
  - A change of `dem_mode` takes effect on the next accepted sample.
  - `ptr_acc` and `lfsr` are never cleared by a mode change.
  - Modes 1 and 2 share `ptr_acc`, so switching between them continues from the current pointer.
- **No accept:** `output_thermometer` and `cycle_index` hold their values, and `output_valid` is 0.
  - `ptr_acc` and `lfsr` hold, except when `lfsr_load` is pulsed.
- **Reset values:**
  - `output_thermometer` = 0.
  - `cycle_index` = 0.
  - `output_valid` = 0.
  - `ptr_acc` = 0.
  - `lfsr` = 16'hACE1.
- **Reset mid-stream:** asserting `rst_n` low clears all outputs and state immediately (asynchronously). The first accept after reset release behaves as the first sample after power-up.

## Timing
- **Latency:** one cycle. A sample accepted at edge k appears on `output_thermometer`, `cycle_index`, and `output_valid`=1 after edge k.
- **Throughput:** one sample per cycle. There is no backpressure, so the block is always ready.
- **Alignment:** `cycle_index` is always the index computed for the thermometer word presented in the same cycle.
- **Pipeline:** no combinational path from inputs to outputs; all outputs come straight from flops.
- **Encoder depth:** the encoder is a single-level compare, bit i = (i < N), and must close timing at the DAC sample clock.

## Structure
- **Shared package `dac_pkg`:**
  - Mode constants `DEM_STATIC`, `DEM_SEQ`, `DEM_DWA`, `DEM_RAND`.
  - LFSR reset seed 16'hACE1.
  - LFSR tap positions.
- **Sub-module `dac_dem_pointer`:** contains the `ptr_acc` and `lfsr` registers, mode mux, and seed-load logic, and outputs the next index. The top level holds the encoder and output registers.

## Test plan
- **Reset:** assert `rst_n` low mid-stream with outputs nonzero -> all outputs 0 immediately; first sample after release in mode 1 yields `cycle_index`=0, the second yields 1.
- **Sequential wrap:** mode 1, 20 consecutive accepts -> indices 0,1,…,15,0,1,2,3; thermometer matches each code with one-cycle latency.
- **DWA:** mode 2, codes 100,100,100 -> indices 0,6,12; `ptr_acc` ends at 44. Code 0 leaves the index unchanged on the next sample.
- **Random:** mode 3 after reset -> the first index is 4'h1 (from ACE1), the next index is taken from the stepped state. A pulse of `lfsr_load` with seed 0 -> the next index is 1.
- **Gating:** `enable`=0 with `sample_valid`=1 -> `output_valid`=0, outputs and pointer hold. `sample_valid` gaps do not advance the index.
- **Extremes:** codes 0 and 255 -> thermometer all-zero, and bits [254:0] set with bit 255 clear.
